// File: rtl/pseudo_linear_pkg.sv
// Shared constants and encodings for the pseudo-linear classifier family
// (inference engine and trainers share the image-word layout).
package pseudo_linear_pkg;

    localparam int NPIX      = 784;            // pixels per image
    localparam int LANES     = 16;             // pixels consumed per cycle
    localparam int CHUNKS    = NPIX / LANES;   // cycles spent in COUNT
    localparam int CNT_W     = 10;             // popcount accumulator width
    localparam int STAT_W    = 16;             // statistics counter width
    localparam int POP_W     = 5;              // width of one LANES-bit popcount
    localparam int PIX_LSB   = 10;             // pixel field LSB in an image word
    localparam int LABEL_BIT = 0;              // label bit position in an image word
    localparam int IMG_W     = NPIX + PIX_LSB; // full image word width

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_CMP   = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/pseudo_linear_infer_if.sv
// Image-in / result-out handshake bundle of the inference engine.
interface pseudo_linear_infer_if #(
    parameter int NPIX = pseudo_linear_pkg::NPIX
) ();
    logic                 img_valid;
    logic                 img_ready;
    logic [NPIX+10-1:0]   img_data;
    logic                 res_valid;
    logic                 res_ready;
    logic                 res_class;
    logic                 res_correct;

    // Producer of images / consumer of results
    modport master (
        output img_valid, img_data, res_ready,
        input  img_ready, res_valid, res_class, res_correct
    );

    // The inference engine
    modport slave (
        input  img_valid, img_data, res_ready,
        output img_ready, res_valid, res_class, res_correct
    );
endinterface

// File: rtl/pseudo_linear_popcnt.sv
// Combinational population count of one LANES-wide chunk.
module pseudo_linear_popcnt #(
    parameter int W  = pseudo_linear_pkg::LANES,
    parameter int OW = pseudo_linear_pkg::POP_W
) (
    input  logic [W-1:0]  vec_i,
    output logic [OW-1:0] cnt_o
);

    // Sum the set bits of the chunk
    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < W; i++) begin
            cnt_o = cnt_o + OW'(vec_i[i]);
        end
    end

endmodule

// File: rtl/pseudo_linear_infer.sv
// Serial inference engine: latches a parameter vector, then for each image
// accumulates popcount(p & pix) and popcount(p) LANES bits per cycle and
// applies the trainer's threshold rule. Keeps saturating accuracy counters.
module pseudo_linear_infer #(
    parameter int NPIX   = pseudo_linear_pkg::NPIX,
    parameter int LANES  = pseudo_linear_pkg::LANES,
    parameter int CNT_W  = pseudo_linear_pkg::CNT_W,
    parameter int STAT_W = pseudo_linear_pkg::STAT_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [3:0]                   threshold,
    input  logic                         param_load,
    input  logic [NPIX-1:0]              param_in,
    pseudo_linear_infer_if.slave         bus,
    input  logic                         clr_stats,
    output logic [STAT_W-1:0]            tot_cnt,
    output logic [STAT_W-1:0]            hit_cnt
);
    import pseudo_linear_pkg::*;

    localparam int NCHUNK = NPIX / LANES;
    localparam int K_W    = $clog2(NCHUNK);
    localparam int PW     = $clog2(LANES + 1);

    state_t              state_q, state_d;
    logic [NPIX-1:0]     p_q, p_d;
    logic [NPIX-1:0]     pix_q, pix_d;
    logic                label_q, label_d;
    logic [3:0]          thr_q, thr_d;
    logic [CNT_W-1:0]    num_q, num_d;
    logic [CNT_W-1:0]    nump_q, nump_d;
    logic [K_W-1:0]      k_q, k_d;
    logic                res_valid_q, res_valid_d;
    logic                res_class_q, res_class_d;
    logic                res_correct_q, res_correct_d;
    logic [STAT_W-1:0]   tot_q, tot_d;
    logic [STAT_W-1:0]   hit_q, hit_d;

    logic [LANES-1:0]    p_chunk_s;
    logic [LANES-1:0]    hit_chunk_s;
    logic [PW-1:0]       pop_hit_s;
    logic [PW-1:0]       pop_p_s;
    logic                class_s;
    logic                res_hs_s;
    logic                unused_s;

    // Chunk k of the latched vectors; no shifting of the wide registers
    assign p_chunk_s   = p_q[k_q*LANES +: LANES];
    assign hit_chunk_s = p_chunk_s & pix_q[k_q*LANES +: LANES];

    pseudo_linear_popcnt #(.W(LANES), .OW(PW)) u_pop_hit (
        .vec_i (hit_chunk_s),
        .cnt_o (pop_hit_s)
    );

    pseudo_linear_popcnt #(.W(LANES), .OW(PW)) u_pop_p (
        .vec_i (p_chunk_s),
        .cnt_o (pop_p_s)
    );

    // Threshold rule: class 0 when the shifted parameter weight covers the hits
    assign class_s  = ((nump_q >> thr_q) >= num_q) ? 1'b0 : 1'b1;
    assign res_hs_s = res_valid_q & bus.res_ready;

    // Reserved image-word bits carry no meaning for inference
    assign unused_s = ^bus.img_data[PIX_LSB-1:1];

    assign bus.img_ready   = (state_q == ST_IDLE) & ~param_load;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_class   = res_class_q;
    assign bus.res_correct = res_correct_q;
    assign tot_cnt         = tot_q;
    assign hit_cnt         = hit_q;

    // FSM next state and datapath next values
    always_comb begin
        state_d       = state_q;
        p_d           = p_q;
        pix_d         = pix_q;
        label_d       = label_q;
        thr_d         = thr_q;
        num_d         = num_q;
        nump_d        = nump_q;
        k_d           = k_q;
        res_valid_d   = res_valid_q;
        res_class_d   = res_class_q;
        res_correct_d = res_correct_q;
        case (state_q)
            ST_IDLE: begin
                if (param_load) begin
                    p_d = param_in;
                end else if (bus.img_valid) begin
                    pix_d   = bus.img_data[PIX_LSB +: NPIX];
                    label_d = bus.img_data[LABEL_BIT];
                    thr_d   = threshold;
                    num_d   = '0;
                    nump_d  = '0;
                    k_d     = '0;
                    state_d = ST_COUNT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COUNT: begin
                num_d  = num_q + CNT_W'(pop_hit_s);
                nump_d = nump_q + CNT_W'(pop_p_s);
                if (k_q == K_W'(NCHUNK - 1)) begin
                    state_d = ST_CMP;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            ST_CMP: begin
                res_class_d   = class_s;
                res_correct_d = class_s ~^ label_q;
                res_valid_d   = 1'b1;
                state_d       = ST_RESP;
            end
            ST_RESP: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Saturating accuracy counters; a clear beats a same-cycle increment
    always_comb begin
        tot_d = tot_q;
        hit_d = hit_q;
        if (clr_stats) begin
            tot_d = '0;
            hit_d = '0;
        end else if (res_hs_s) begin
            if (tot_q != {STAT_W{1'b1}}) begin
                tot_d = tot_q + STAT_W'(1);
            end else begin
                tot_d = tot_q;
            end
            if (res_correct_q && (hit_q != {STAT_W{1'b1}})) begin
                hit_d = hit_q + STAT_W'(1);
            end else begin
                hit_d = hit_q;
            end
        end else begin
            tot_d = tot_q;
            hit_d = hit_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            p_q           <= '0;
            pix_q         <= '0;
            label_q       <= 1'b0;
            thr_q         <= 4'd0;
            num_q         <= '0;
            nump_q        <= '0;
            k_q           <= '0;
            res_valid_q   <= 1'b0;
            res_class_q   <= 1'b0;
            res_correct_q <= 1'b0;
            tot_q         <= '0;
            hit_q         <= '0;
        end else begin
            state_q       <= state_d;
            p_q           <= p_d;
            pix_q         <= pix_d;
            label_q       <= label_d;
            thr_q         <= thr_d;
            num_q         <= num_d;
            nump_q        <= nump_d;
            k_q           <= k_d;
            res_valid_q   <= res_valid_d;
            res_class_q   <= res_class_d;
            res_correct_q <= res_correct_d;
            tot_q         <= tot_d;
            hit_q         <= hit_d;
        end
    end

endmodule

// File: doc/pseudo_linear_infer.md
# pseudo_linear_infer

Inference engine for the pseudo-linear MNIST classifiers. It latches a trained 784-bit parameter vector, taken from a trainer's `pm` output. It then accepts packed image words through a valid/ready handshake. For each image it computes the two popcounts serially, 16 pixels per cycle, and applies the same threshold rule the trainer uses. It returns a class bit and a correctness flag, and keeps running accuracy counters.

## Interface
Parameters:
- `NPIX`, 784, pixels per image
- `LANES`, 16, pixels processed per cycle; `NPIX % LANES == 0`
- `CNT_W`, 10, popcount accumulator width
- `STAT_W`, 16, statistics counter width

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `threshold`  in  4  shift amount; sampled at image accept
- `param_load`  in  1  pulse; latch `param_in` (honoured in IDLE only)
- `param_in`  in  NPIX  parameter vector; bit i pairs with pixel i
- `img_valid`  in  1  image word valid
- `img_ready`  out  1  engine can accept an image
- `img_data`  in  NPIX+10  pixels at [NPIX+9:10], label bit at [0]; bits [9:1] ignored
- `res_valid`  out  1  result valid
- `res_ready`  in  1  result consumed
- `res_class`  out  1  predicted bit
- `res_correct`  out  1  `res_class == label`
- `clr_stats`  in  1  synchronous clear of statistics
- `tot_cnt`  out  STAT_W  results delivered
- `hit_cnt`  out  STAT_W  correct results delivered

## Operation
- FSM states: IDLE → COUNT → CMP → RESP → IDLE.
- IDLE:
  - `img_ready = !param_load`.
  - `param_load` latches `param_in`. It takes priority, so no image is accepted in that cycle.
  - On `img_valid & img_ready`, latch pixels, label and `threshold`, clear `num`, `num_p` and chunk index `k`, then go to COUNT.
- COUNT, per cycle for chunk `k` (0..CHUNKS-1, CHUNKS = NPIX/LANES = 49):
  - `num += popcount(p[k] & pix[k])`
  - `num_p += popcount(p[k])`
  - On the last chunk, go to CMP.
- CMP:
  - `res_class = ((num_p >> thr) >= num) ? 0 : 1`.
  - `res_correct = res_class ~^ label`.
  - Set `res_valid`, then go to RESP.
- RESP:
  - Hold `res_valid`, `res_class` and `res_correct` stable until `res_ready`.
  - On the handshake, clear `res_valid` and go to IDLE.
- `param_load` outside IDLE is ignored; an in-flight image always uses the parameters latched before its accept.
- Arithmetic:
  - Accumulators are `CNT_W` bits; the maximum is 784, so there is no overflow.
  - The shift is a logical right shift of the 10-bit `num_p` by 0..15.
- Statistics:
  - On the result handshake, `tot_cnt += 1`, and `hit_cnt += 1` if `res_correct`.
  - Both counters saturate at all-ones.
  - `clr_stats` zeroes both and wins over a same-cycle increment.

## Timing
- All outputs are registered except `img_ready`, which is IDLE gated by `param_load`.
- Reset values: state IDLE, `p` = 0, `res_valid` = 0, `res_class` = 0, `res_correct` = 0, `tot_cnt` = 0, `hit_cnt` = 0. `img_ready` = 1 after reset while `param_load` is low.
- Latency: image accept at edge E0; chunks are accumulated at E1..E49; `res_valid` rises after E50.
- Minimum period: 52 cycles per image when `res_ready` is held high. The result handshake is at E51 and the next accept is at E52.
- Reset mid-operation: the block returns to IDLE, clears the parameters and statistics, and discards any pending result.

## Structure
- Shared package `pseudo_linear_pkg` holds:
  - `NPIX`, `LANES`, `CHUNKS`, `CNT_W`
  - state encodings IDLE/COUNT/CMP/RESP
  - the image-word field offsets (pixel LSB = 10, label = 0), shared with the trainers.
- Sub-module `pseudo_linear_popcnt`: a combinational `LANES`-bit popcount returning a 5-bit result. It is instanced twice, once for `p & pix` and once for `p`.
- Chunk selection uses an indexed part-select of the latched vectors by `k`. No shifting of the 784-bit registers is required.

## Test plan
- Parameters all-ones, image all-ones, thr = 0:
  - num = num_p = 784, and 784 >= 784, so class 0.
  - Label 0 gives `res_correct` = 1, with `res_valid` rising exactly 50 cycles after accept.
- Parameters all-ones, image with 100 pixels set, thr = 3:
  - num_p >> 3 = 98, and 98 < 100, so class 1.
  - Repeating with 98 pixels set gives class 0 (equality boundary).
- `param_load` asserted together with `img_valid` in IDLE:
  - `img_ready` = 0 and the new parameters are latched.
  - The image is accepted the following cycle and uses the new parameters.
- `param_load` pulsed during COUNT:
  - Ignored; the result matches the old parameters and a later image still uses the old vector.
- `res_ready` held low for 20 cycles:
  - `res_valid` and the result stay stable and `img_ready` stays 0.
  - Counters update only at the handshake.
- Statistics:
  - Preload near saturation via 65535 results (or force), then confirm `tot_cnt` holds at 0xFFFF.
  - Assert `clr_stats` on a handshake cycle and confirm both counters read 0.
  - Assert `rst_n` low mid-COUNT and confirm all reset values.
